// File: rtl/regfile_mp.sv
// Multi-port register file with issue scoreboard and a sequential clear engine.
// Two write ports, NRD combinational read ports, optional zero register and write forwarding.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we0,
  input  logic               we1,
  input  logic [AW-1:0]      waddr0,
  input  logic [AW-1:0]      waddr1,
  input  logic [XLEN-1:0]    wdata0,
  input  logic [XLEN-1:0]    wdata1,
  input  logic [NRD*AW-1:0]  raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]     rbusy,
  input  logic               iss_valid,
  input  logic [AW-1:0]      iss_rd,
  input  logic               clr_req,
  output logic               clr_busy,
  output logic               clr_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} clr_state_e;

  clr_state_e       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             wr0_ok, wr1_ok, iss_ok, clr_start, fwd_en;
  logic [AW-1:0]    ra;

  // The clear engine owns the array while it runs: all external updates are locked out.
  assign wr0_ok    = we0 && !clr_busy && !((ZERO_REG != 0) && (waddr0 == '0));
  assign wr1_ok    = we1 && !clr_busy && !((ZERO_REG != 0) && (waddr1 == '0));
  assign iss_ok    = iss_valid && !clr_busy;
  assign clr_start = clr_req && (state_q == IDLE);
  assign fwd_en    = (BYPASS != 0) && rst && !clr_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NREGS - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (state_q != IDLE);
    clr_done = (state_q == DONE);
  end

  // Port 1 is applied last so it wins on an address collision; issue is applied after
  // the write-side clears so a same-cycle set wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (state_q == SWEEP) regs_d[idx_q] = '0;
    if (wr0_ok) begin
      regs_d[waddr0] = wdata0;
      busy_d[waddr0] = 1'b0;
    end
    if (wr1_ok) begin
      regs_d[waddr1] = wdata1;
      busy_d[waddr1] = 1'b0;
    end
    if (iss_ok) busy_d[iss_rd] = 1'b1;
    if (clr_start) busy_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      // NOTE: the array lives in flops with async reset because reset must zero every entry at once.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = raddr[k*AW +: AW];
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rdata[k*XLEN +: XLEN] = '0;
      end else if (fwd_en && we1 && (waddr1 == ra)) begin
        rdata[k*XLEN +: XLEN] = wdata1;
      end else if (fwd_en && we0 && (waddr0 == ra)) begin
        rdata[k*XLEN +: XLEN] = wdata0;
      end else begin
        rdata[k*XLEN +: XLEN] = regs_q[ra];
      end
      rbusy[k] = busy_q[ra] && !((ZERO_REG != 0) && (ra == '0));
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: per-cycle comparison against an array model
// of the register file, plus directed scenarios with hand-computed expectations.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                we0, we1;
  logic [AW-1:0]       waddr0, waddr1;
  logic [XLEN-1:0]     wdata0, wdata1;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                clr_req;
  logic                clr_busy, clr_done;

  int passed = 0;
  int total  = 0;

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Model: plain arrays plus a clear-progress count (0 = idle, 1..NREGS = sweeping, NREGS+1 = done).
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  int              m_phase;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0;
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else if (m_phase != 0) begin
      if (m_phase <= NREGS) m_regs[m_phase-1] = '0;
      m_phase = (m_phase == NREGS + 1) ? 0 : m_phase + 1;
    end else begin
      if (we0 && waddr0 != 0) begin m_regs[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
      if (we1 && waddr1 != 0) begin m_regs[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      if (clr_req) begin
        for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
        m_phase = 1;
      end
    end
  end

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    bit fwd;
    fwd = rst && (m_phase == 0);
    if (a == 0) return '0;
    if (fwd && we1 && waddr1 == a) return wdata1;
    if (fwd && we0 && waddr0 == a) return wdata0;
    return m_regs[a];
  endfunction

  always @(negedge clk) begin
    logic [AW-1:0] a;
    for (int k = 0; k < NRD; k++) begin
      a = raddr[k*AW +: AW];
      check("model_rdata", rdata[k*XLEN +: XLEN], exp_rd(a));
      check("model_rbusy", rbusy[k], (a != 0) ? m_busy[a] : 1'b0);
    end
    check("model_clr_busy", clr_busy, m_phase != 0);
    check("model_clr_done", clr_done, m_phase == NREGS + 1);
  end

  task automatic idle();
    we0 = 0; we1 = 0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    iss_valid = 0; iss_rd = '0; clr_req = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int busy_cycles, done_pulses;

  initial begin
    rst = 1'b0;
    raddr = '0;
    idle();
    #12 rst = 1'b1;

    @(negedge clk);
    check("reset_rdata", rdata, 64'h0);
    check("reset_clr_busy", clr_busy, 1'b0);

    // Write 0xDEADBEEF to r5, read it on both ports.
    step(); we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
    step(); idle(); raddr = {5'd5, 5'd5};
    @(negedge clk);
    check("r5_port0", rdata[31:0], 32'hDEADBEEF);
    check("r5_port1", rdata[63:32], 32'hDEADBEEF);

    // Both ports write r7: forwarding and storage prefer port 1.
    step(); we0 = 1; waddr0 = 7; wdata0 = 32'h11; we1 = 1; waddr1 = 7; wdata1 = 32'h22; raddr = {5'd7, 5'd7};
    @(negedge clk);
    check("r7_bypass", rdata[31:0], 32'h22);
    step(); idle();
    @(negedge clk);
    check("r7_stored", rdata[63:32], 32'h22);

    // Zero register.
    step(); we0 = 1; waddr0 = 0; wdata0 = 32'h1234; raddr = {5'd0, 5'd0};
    @(negedge clk);
    check("r0_bypass", rdata[31:0], 32'h0);
    step(); idle();
    @(negedge clk);
    check("r0_stored", rdata[31:0], 32'h0);

    // Scoreboard: set beats clear, then a plain write clears.
    step(); iss_valid = 1; iss_rd = 9; raddr = {5'd9, 5'd9};
    @(negedge clk);
    check("r9_not_yet_busy", rbusy, 2'b00);
    step(); iss_valid = 1; iss_rd = 9; we0 = 1; waddr0 = 9; wdata0 = 32'h99;
    step(); idle();
    @(negedge clk);
    check("r9_set_wins", rbusy, 2'b11);
    step(); we1 = 1; waddr1 = 9; wdata1 = 32'h5;
    step(); idle();
    @(negedge clk);
    check("r9_cleared", rbusy, 2'b00);
    check("r9_data", rdata[31:0], 32'h5);

    // Fill every register, mark r12 busy, then run a clear.
    for (int i = 0; i < NREGS; i++) begin
      step(); idle(); we0 = 1; waddr0 = AW'(i); wdata0 = 32'hA5000000 | i;
    end
    step(); idle(); iss_valid = 1; iss_rd = 12; raddr = {5'd31, 5'd1};
    @(negedge clk);
    check("fill_r1", rdata[31:0], 32'hA5000001);
    check("fill_r31", rdata[63:32], 32'hA500001F);
    step(); idle(); clr_req = 1; raddr = {5'd12, 5'd12};
    step(); idle();
    busy_cycles = 0;
    done_pulses = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!clr_busy) break;
      if (c == 0) check("sweep_busy_cleared", rbusy, 2'b00);
      busy_cycles++;
      if (clr_done) done_pulses++;
      step(); idle();
      if (c == 5) begin
        we0 = 1; waddr0 = 2; wdata0 = 32'hFFFF; iss_valid = 1; iss_rd = 3; clr_req = 1; raddr = {5'd2, 5'd2};
      end
    end
    check("clr_busy_cycles", busy_cycles, NREGS + 1);
    check("clr_done_pulses", done_pulses, 1);
    for (int i = 0; i < NREGS / 2; i++) begin
      step(); idle(); raddr = {AW'(2*i+1), AW'(2*i)};
      @(negedge clk);
      check("cleared_pair", rdata, 64'h0);
      if (i == 1) check("r3_iss_ignored", rbusy, 2'b00);
    end
    check("no_restart", clr_busy, 1'b0);

    // Reset in the middle of a sweep.
    step(); idle(); we0 = 1; waddr0 = 5; wdata0 = 32'h55; we1 = 1; waddr1 = 20; wdata1 = 32'h2020;
    step(); idle(); raddr = {5'd20, 5'd5};
    @(negedge clk);
    check("pre_sweep_r5", rdata[31:0], 32'h55);
    check("pre_sweep_r20", rdata[63:32], 32'h2020);
    step(); clr_req = 1;
    step(); idle();
    repeat (10) step();
    #2 rst = 1'b0;
    #1;
    check("abort_clr_busy", clr_busy, 1'b0);
    check("abort_clr_done", clr_done, 1'b0);
    check("abort_rdata", rdata, 64'h0);
    @(negedge clk);
    #1 rst = 1'b1;
    we0 = 1; waddr0 = 3; wdata0 = 32'h333; raddr = {5'd3, 5'd3};
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    check("post_reset_r3", rdata[31:0], 32'h333);
    check("post_reset_idle", clr_busy, 1'b0);

    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, >= 2; AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports, 1..4.
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 = register 0 reads zero and ignores writes.
REQ-005 SHALL have parameter BYPASS, default 1; 1 = same-cycle write data forwarded to reads.
REQ-006 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port: rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-008 SHALL have ports: we0/we1  input  1  write enables, port 0 and port 1.
REQ-009 SHALL have ports: waddr0/waddr1  input  AW  write addresses.
REQ-010 SHALL have ports: wdata0/wdata1  input  XLEN  write data.
REQ-011 SHALL have port: raddr  input  NRD*AW  packed read addresses, port k at bits [k*AW +: AW].
REQ-012 SHALL have port: rdata  output  NRD*XLEN  packed read data, combinational.
REQ-013 SHALL have port: rbusy  output  NRD  scoreboard busy bit of each read address, combinational.
REQ-014 SHALL have ports: iss_valid  input  1, iss_rd  input  AW  -- destination register issue (marks busy).
REQ-015 SHALL have port: clr_req  input  1  request to zero all registers.
REQ-016 SHALL have ports: clr_busy  output  1, clr_done  output  1 (one-cycle pulse).

Function
REQ-017 Writes SHALL commit on the rising clk edge; both ports may write in the same cycle.
REQ-018 When we0 and we1 target the same address, port 1 data SHALL be stored.
REQ-019 With ZERO_REG=1, writes to address 0 SHALL be dropped, and reads and rbusy of address 0 SHALL return 0.
REQ-020 With BYPASS=1, a read matching an enabled write address in the same cycle SHALL return that write's data (port 1 over port 0); with BYPASS=0 it SHALL return the stored value.
REQ-021 The scoreboard SHALL hold one busy bit per register.
REQ-022 iss_valid SHALL set busy[iss_rd] at the edge.
REQ-023 Any accepted write to a register SHALL clear its busy bit.
REQ-024 When a busy bit is set and cleared in the same cycle, set SHALL win.
REQ-025 rbusy SHALL reflect stored busy bits only, with no bypass.
REQ-026 Clear FSM states SHALL be IDLE, SWEEP and DONE.
REQ-027 IDLE->SWEEP SHALL occur on clr_req=1; the index counter loads 0 and all busy bits clear at that edge.
REQ-028 In SWEEP the FSM SHALL zero register[idx] each cycle and increment idx, moving to DONE after idx = NREGS-1; the sweep takes exactly NREGS cycles.
REQ-029 DONE SHALL last one cycle with clr_done=1, then return to IDLE.
REQ-030 clr_busy SHALL be 1 in SWEEP and DONE.
REQ-031 While clr_busy=1: we0, we1, iss_valid and clr_req SHALL be ignored, and BYPASS forwarding SHALL be disabled.
REQ-032 The counter SHALL be AW bits wide and SHALL wrap without spurious transitions.

Reset
REQ-033 While rst=0, all registers, all busy bits and idx SHALL be 0, the FSM SHALL be IDLE, and clr_busy and clr_done SHALL be 0, asynchronously.
REQ-034 Reset asserted mid-SWEEP SHALL abort the sweep; after release the block SHALL be IDLE and accept writes on the first edge.

Verification
REQ-035 Case: write 0xDEADBEEF to r5 via port 0, then read r5 on ports 0 and 1 -> both return 0xDEADBEEF.
REQ-036 Case: we0 and we1 both to r7 with data 0x11 and 0x22, raddr=r7 in the same cycle -> BYPASS=1 rdata=0x22 combinationally; next cycle stored value = 0x22.
REQ-037 Case: write 0x1234 to r0 -> r0 reads 0 (ZERO_REG=1).
REQ-038 Case: iss r9, then next cycle iss r9 together with a write to r9 -> rbusy for r9 stays 1; a later write-only to r9 -> rbusy = 0.
REQ-039 Case: fill all registers, pulse clr_req -> clr_busy high for NREGS+1 cycles, clr_done pulses exactly once, all reads 0, a write during SWEEP is ignored.
REQ-040 Case: assert rst low at idx=10 of a sweep -> all outputs 0 immediately; after release, a write to r3 succeeds on the first edge.
